// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the CNN image feeder.
// The feeder streams a buffered image into the CNN core and captures its class decision.
package cnn_pkg;

    localparam int DATA_BITS      = 8;
    localparam int IMG_PIXELS     = 784;
    localparam int ADDR_BITS      = 10;
    localparam int TIMEOUT_CYCLES = 4096;

    localparam logic [3:0] RESULT_TIMEOUT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CNNRST = 2'd1,
        ST_STREAM = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

endpackage

// File: rtl/frame_ram.sv
// Single-port-write / single-port-read image buffer with a registered read.
// It maps onto block RAM and has no reset, so its contents survive a reset.
module frame_ram #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 784,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/image_feeder.sv
// Buffers one image, then resets the CNN core, streams every pixel without
// bubbles and waits (bounded) for the core's class decision.
module image_feeder #(
    parameter int DATA_BITS      = cnn_pkg::DATA_BITS,
    parameter int IMG_PIXELS     = cnn_pkg::IMG_PIXELS,
    parameter int TIMEOUT_CYCLES = cnn_pkg::TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [9:0]           wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 cnn_rst_n,
    output logic [DATA_BITS-1:0] pix_out,
    output logic                 pix_valid,
    input  logic                 cnn_valid,
    input  logic [3:0]           cnn_decision,
    output logic [3:0]           result,
    output logic                 result_valid,
    output logic                 timeout
);

    import cnn_pkg::*;

    localparam int PCNT_BITS = $clog2(IMG_PIXELS);
    localparam int WCNT_BITS = $clog2(TIMEOUT_CYCLES + 1);

    state_t                 state_reg, state_next;
    logic [PCNT_BITS-1:0]   pix_cnt_reg;
    logic [WCNT_BITS-1:0]   wait_cnt_reg;
    logic [3:0]             result_reg;
    logic                   result_valid_reg;
    logic                   timeout_reg;
    logic                   cnn_rst_n_reg;
    logic                   ram_we;
    logic [9:0]             rd_addr;
    logic [DATA_BITS-1:0]   rd_data;
    logic                   last_pix;
    logic                   wait_expired;

    assign last_pix     = (pix_cnt_reg == PCNT_BITS'(IMG_PIXELS - 1));
    assign wait_expired = (wait_cnt_reg == WCNT_BITS'(TIMEOUT_CYCLES - 1));
    assign ram_we       = wr_en && (state_reg == ST_IDLE) && (int'(wr_addr) < IMG_PIXELS);

    frame_ram #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (IMG_PIXELS),
        .ADDR_BITS (10)
    ) u_frame_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_CNNRST;
            ST_CNNRST: state_next = ST_STREAM;
            ST_STREAM: if (last_pix) state_next = ST_WAIT;
            ST_WAIT:   if (cnn_valid || wait_expired) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Read address runs one pixel ahead of the pixel being presented.
    always_comb begin
        busy      = (state_reg != ST_IDLE);
        pix_valid = (state_reg == ST_STREAM);
        pix_out   = pix_valid ? rd_data : '0;
        rd_addr   = '0;
        if (state_reg == ST_STREAM && !last_pix) begin
            rd_addr = 10'(pix_cnt_reg + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt_reg      <= '0;
            wait_cnt_reg     <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            timeout_reg      <= 1'b0;
            cnn_rst_n_reg    <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;
            timeout_reg      <= 1'b0;
            cnn_rst_n_reg    <= (state_next != ST_CNNRST);

            if (state_reg == ST_STREAM && !last_pix) begin
                pix_cnt_reg <= pix_cnt_reg + 1'b1;
            end else begin
                pix_cnt_reg <= '0;
            end

            if (state_reg == ST_WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
                if (cnn_valid) begin
                    result_reg       <= cnn_decision;
                    result_valid_reg <= 1'b1;
                end else if (wait_expired) begin
                    result_reg       <= RESULT_TIMEOUT;
                    result_valid_reg <= 1'b1;
                    timeout_reg      <= 1'b1;
                end
            end else begin
                wait_cnt_reg <= '0;
            end
        end
    end

    // Gating with rst_n keeps the core in reset for as long as we are.
    assign cnn_rst_n    = rst_n & cnn_rst_n_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign timeout      = timeout_reg;

endmodule

// File: tb/tb_image_feeder.sv
// Directed bench for image_feeder: streaming, result capture, timeout,
// dropped writes, ignored start, and mid-stream reset.
module tb_image_feeder;

    localparam int NPIX = 784;
    localparam int TOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic       cnn_rst_n;
    logic [7:0] pix_out;
    logic       pix_valid;
    logic       cnn_valid;
    logic [3:0] cnn_decision;
    logic [3:0] result;
    logic       result_valid;
    logic       timeout;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_mem [NPIX];

    image_feeder #(
        .DATA_BITS      (8),
        .IMG_PIXELS     (NPIX),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .start        (start),
        .busy         (busy),
        .cnn_rst_n    (cnn_rst_n),
        .pix_out      (pix_out),
        .pix_valid    (pix_valid),
        .cnn_valid    (cnn_valid),
        .cnn_decision (cnn_decision),
        .result       (result),
        .result_valid (result_valid),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_cnnrst"}, cnn_rst_n, 0);
        check({tag, "_pvalid"}, pix_valid, 0);
        check({tag, "_pout"},  pix_out, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_rvalid"}, result_valid, 0);
        check({tag, "_tout"},  timeout, 0);
    endtask

    // Pulses start (plus any write already set up by the caller) and checks the
    // whole stream against exp_mem. rst_at >= 0 resets the DUT at that pixel.
    task automatic stream_run(input string tag, input int rst_at, input bit disturb);
        int bad_data;
        int bad_rv;
        bad_data = 0;
        bad_rv   = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        check({tag, "_cnnrst_low"}, cnn_rst_n, 0);
        check({tag, "_cnnrst_busy"}, busy, 1);
        check({tag, "_cnnrst_novalid"}, pix_valid, 0);
        tick();
        check({tag, "_cnnrst_released"}, cnn_rst_n, 1);
        check({tag, "_pixel0"}, pix_out, exp_mem[0]);
        for (int k = 0; k < NPIX; k++) begin
            if (pix_valid !== 1'b1 || pix_out !== exp_mem[k]) bad_data++;
            if (result_valid !== 1'b0) bad_rv++;
            wr_en     = 1'b0;
            start     = 1'b0;
            cnn_valid = 1'b0;
            if (k == rst_at) begin
                rst_n = 1'b0;
                tick();
                check_reset_outputs({tag, "_midreset"});
                check({tag, "_pixels_before_reset"}, bad_data, 0);
                rst_n = 1'b1;
                tick();
                check({tag, "_post_reset_cnnrst"}, cnn_rst_n, 1);
                check({tag, "_post_reset_idle"}, busy, 0);
                check({tag, "_post_reset_norv"}, result_valid, 0);
                return;
            end
            if (disturb && k == 100) begin
                wr_en = 1'b1; wr_addr = 10'd5; wr_data = 8'hAA;
            end
            if (disturb && k == 200) start = 1'b1;
            if (disturb && k == 300) begin
                cnn_valid = 1'b1; cnn_decision = 4'd7;
            end
            tick();
        end
        wr_en     = 1'b0;
        start     = 1'b0;
        cnn_valid = 1'b0;
        check({tag, "_stream_bad_pixels"}, bad_data, 0);
        check({tag, "_no_rv_in_stream"}, bad_rv, 0);
        check({tag, "_end_pvalid"}, pix_valid, 0);
        check({tag, "_end_pout"}, pix_out, 0);
        check({tag, "_wait_busy"}, busy, 1);
    endtask

    task automatic finish_with(input string tag, input logic [3:0] dec);
        tick();
        tick();
        tick();
        check({tag, "_wait_no_rv"}, result_valid, 0);
        check({tag, "_wait_still_busy"}, busy, 1);
        cnn_valid    = 1'b1;
        cnn_decision = dec;
        tick();
        cnn_valid    = 1'b0;
        check({tag, "_result"}, result, dec);
        check({tag, "_rvalid"}, result_valid, 1);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_no_timeout"}, timeout, 0);
        tick();
        check({tag, "_rvalid_pulse"}, result_valid, 0);
        check({tag, "_result_hold"}, result, dec);
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        start        = 1'b0;
        cnn_valid    = 1'b0;
        cnn_decision = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        check("reset_release_cnnrst", cnn_rst_n, 1);

        for (int k = 0; k < NPIX; k++) begin
            wr_en = 1'b1; wr_addr = 10'(k); wr_data = 8'(k);
            exp_mem[k] = 8'(k);
            tick();
        end
        wr_en = 1'b1; wr_addr = 10'd800; wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        check("idle_after_load", busy, 0);

        // Busy write to addr 5, second start and stray cnn_valid all ignored.
        stream_run("run1", -1, 1'b1);
        finish_with("run1", 4'd2);

        // Addr 5 must still hold 5; no cnn_valid so the wait times out.
        check("run2_prev_result", result, 2);
        stream_run("run2", -1, 1'b0);
        n = 0;
        while (result_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("run2_timeout_cycles", n, TOUT);
        check("run2_timeout", timeout, 1);
        check("run2_result_f", result, 4'hF);
        check("run2_timeout_idle", busy, 0);
        tick();
        check("run2_timeout_pulse", timeout, 0);
        check("run2_rv_pulse", result_valid, 0);
        check("run2_result_hold", result, 4'hF);

        // Write and start in the same IDLE cycle: the new pixel is streamed.
        wr_en = 1'b1; wr_addr = 10'd0; wr_data = 8'h5A;
        exp_mem[0] = 8'h5A;
        stream_run("run3", -1, 1'b0);
        finish_with("run3", 4'd9);

        stream_run("run4", 300, 1'b0);
        stream_run("run5", -1, 1'b0);
        finish_with("run5", 4'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/image_feeder.md
IMAGE_FEEDER -- requirements
Module: image_feeder

Interface
REQ-001 Parameter DATA_BITS, default 8, pixel width in bits.
REQ-002 Parameter IMG_PIXELS, default 784, pixels per image (28x28).
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, maximum WAIT-state cycles before abort.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 wr_en  input  1  frame-buffer write strobe.
REQ-007 wr_addr  input  10  frame-buffer write address, 0..IMG_PIXELS-1.
REQ-008 wr_data  input  DATA_BITS  pixel value to write.
REQ-009 start  input  1  one-cycle request to stream the buffered image.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 cnn_rst_n  output  1  reset to CNN core; active-low.
REQ-012 pix_out  output  DATA_BITS  pixel to CNN data input.
REQ-013 pix_valid  output  1  pix_out carries a live pixel.
REQ-014 cnn_valid  input  1  CNN result-valid (valid_out_6).
REQ-015 cnn_decision  input  4  CNN class, 0..9.
REQ-016 result  output  4  captured class; 4'hF on timeout.
REQ-017 result_valid  output  1  one-cycle pulse, result updated.
REQ-018 timeout  output  1  one-cycle pulse, coincident with result_valid on abort.

Function
REQ-019 States IDLE, CNNRST, STREAM, WAIT; one-hot or binary encoding allowed.
REQ-020 IDLE: start=1 -> CNNRST; otherwise stay.
REQ-021 CNNRST: lasts exactly 1 cycle with cnn_rst_n=0; -> STREAM; cnn_rst_n=1 in every other state.
REQ-022 STREAM: pix_valid=1 for exactly IMG_PIXELS consecutive cycles; in k-th such cycle (k=0..IMG_PIXELS-1) pix_out=mem[k]; -> WAIT after pixel IMG_PIXELS-1.
REQ-023 Latency: start sampled at edge N -> cnn_rst_n low during cycle N+1 -> pixel 0 during cycle N+2.
REQ-024 pix_out=0 whenever pix_valid=0.
REQ-025 Frame buffer: synchronous-read RAM, 1-cycle read latency; read address is issued one cycle ahead so no bubbles occur in STREAM.
REQ-026 WAIT: cnn_valid=1 -> result<=cnn_decision, result_valid pulses 1 cycle, -> IDLE.
REQ-027 WAIT: cycle counter starts at 0 on entry; if it reaches TIMEOUT_CYCLES with cnn_valid never seen -> result<=4'hF, result_valid and timeout pulse 1 cycle, -> IDLE.
REQ-028 cnn_valid sampled outside WAIT is ignored.
REQ-029 Writes accepted only in IDLE; wr_en while busy is dropped, buffer unchanged.
REQ-030 wr_addr>=IMG_PIXELS: write dropped.
REQ-031 start while busy is ignored; no queuing.
REQ-032 wr_en and start in same IDLE cycle: write commits and start is accepted; the new pixel is streamed.
REQ-033 result holds its value until the next result_valid.

Reset
REQ-034 rst_n=0 at a rising edge forces IDLE, busy=0, cnn_rst_n=0, pix_valid=0, pix_out=0, result=0, result_valid=0, timeout=0, counters=0.
REQ-035 cnn_rst_n follows rst_n (low during reset), so reset mid-operation also resets the CNN core.
REQ-036 Reset mid-STREAM or mid-WAIT aborts with no result_valid; frame-buffer contents are not cleared.

Structure
REQ-037 Shared package cnn_pkg holds DATA_BITS, IMG_PIXELS, the state encoding and RESULT_TIMEOUT (4'hF).
REQ-038 Frame buffer is one sub-module frame_ram (1 write port, 1 synchronous read port, IMG_PIXELS x DATA_BITS).

Verification
REQ-039 Load mem[k]=k mod 256, pulse start -> cnn_rst_n low 1 cycle, then 784 valid cycles with pix_out 0,1,..,255,0,..; pixel 0 at N+2.
REQ-040 After stream, drive cnn_valid=1 with cnn_decision=4'd2 -> result=2, result_valid 1 cycle, busy=0 next cycle.
REQ-041 Never assert cnn_valid, TIMEOUT_CYCLES=16 -> timeout and result_valid together, result=4'hF, back to IDLE.
REQ-042 wr_en to addr 5 with data 8'hAA during STREAM, and to addr 800 in IDLE -> next run streams original mem[5]; no corruption.
REQ-043 Assert rst_n=0 at pixel 300 -> all outputs at reset values next cycle, no result_valid; new start re-streams from pixel 0 with unchanged buffer.
REQ-044 Second start pulse during STREAM -> ignored; exactly 784 pixels and one result_valid.
